// File: rtl/uart_rx_sampler.sv
// UART receive sampler: synchronises the raw rx line, detects start bits,
// emits mid-bit sample strobes from a runtime divisor, assembles the data
// word and checks parity / stop bits for a runtime-selected frame format.
//
// Ports:
//   ref_clk, reset      clock (posedge) and synchronous active-low reset
//   rx                  asynchronous serial line, idles high
//   enable              permits detection of new start bits
//   div_wr, div_in      load strobe and value for the baud divisor register
//   data_bits           0..3 -> 5..8 data bits
//   parity_en/odd       parity bit present / odd sense
//   stop2               two stop bits when set
//   sample_pulse        one-cycle strobe at each bit centre
//   sample_bit, bit_idx synchronised rx value and frame bit index at the strobe
//   busy                high from start detection until back in IDLE
//   frame_done          one-cycle pulse; data_out and error flags valid
//   data_out            received word, right-aligned
//   parity_err/stop_err frame error flags, held until the next start
//   false_start         one-cycle pulse on a rejected start bit
module uart_rx_sampler #(
   parameter int unsigned DIV_W       = 16,
   parameter int unsigned DEFAULT_DIV = 15259,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             ref_clk,
   input  logic             reset,
   input  logic             rx,
   input  logic             enable,
   input  logic             div_wr,
   input  logic [DIV_W-1:0] div_in,
   input  logic [1:0]       data_bits,
   input  logic             parity_en,
   input  logic             parity_odd,
   input  logic             stop2,
   output logic             sample_pulse,
   output logic             sample_bit,
   output logic [3:0]       bit_idx,
   output logic             busy,
   output logic             frame_done,
   output logic [7:0]       data_out,
   output logic             parity_err,
   output logic             stop_err,
   output logic             false_start
);

   localparam int unsigned MIN_DIV = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_t;

   state_t state_q, state_d;

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;
   logic                   rx_s;
   logic                   start_edge;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] cnt_nxt;
   logic             cnt_wrap;
   logic             cnt_hit;
   logic [3:0]       bit_q, bit_d;
   logic [DIV_W-1:0] div_reg_q, div_reg_d;
   logic [DIV_W-1:0] act_div_q, act_div_d;
   logic [DIV_W-1:0] half_q, half_d;
   logic [1:0]       fmt_bits_q, fmt_bits_d;
   logic             fmt_par_q, fmt_par_d;
   logic             fmt_odd_q, fmt_odd_d;
   logic             fmt_stop2_q, fmt_stop2_d;
   logic [7:0]       sh_q, sh_d;
   logic             acc_q, acc_d;
   logic [3:0]       n_bits;
   logic [3:0]       last_idx;
   logic             reject;

   logic             sample_pulse_d, sample_bit_d, busy_d, frame_done_d;
   logic [3:0]       bit_idx_d;
   logic [7:0]       data_out_d;
   logic             parity_err_d, stop_err_d, false_start_d;

   // Synchronised line value and its falling edge
   assign rx_s       = sync_q[SYNC_STAGES-1];
   assign start_edge = prev_q & ~rx_s;

   // Baud counter wraps at div-1; a sample falls where the next count hits H
   assign cnt_wrap = (cnt_q == act_div_q - DIV_W'(1));
   assign cnt_nxt  = cnt_wrap ? '0 : cnt_q + DIV_W'(1);
   assign cnt_hit  = (state_q != IDLE) && (cnt_nxt == half_q);

   // Frame geometry from the latched format: data bits occupy idx 1..n_bits
   assign n_bits   = 4'(fmt_bits_q) + 4'd5;
   assign last_idx = n_bits + 4'(fmt_par_q) + 4'(fmt_stop2_q) + 4'd1;
   assign reject   = (state_q == START) && rx_s;

   // State and datapath registers
   always_ff @(posedge ref_clk) begin
      if (!reset) begin
         state_q      <= IDLE;
         sync_q       <= '1;
         prev_q       <= 1'b1;
         cnt_q        <= '0;
         bit_q        <= '0;
         div_reg_q    <= DIV_W'(DEFAULT_DIV);
         act_div_q    <= DIV_W'(DEFAULT_DIV);
         half_q       <= DIV_W'(DEFAULT_DIV >> 1);
         fmt_bits_q   <= '0;
         fmt_par_q    <= 1'b0;
         fmt_odd_q    <= 1'b0;
         fmt_stop2_q  <= 1'b0;
         sh_q         <= '0;
         acc_q        <= 1'b0;
         sample_pulse <= 1'b0;
         sample_bit   <= 1'b0;
         bit_idx      <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         data_out     <= '0;
         parity_err   <= 1'b0;
         stop_err     <= 1'b0;
         false_start  <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync_q       <= {sync_q[SYNC_STAGES-2:0], rx};
         prev_q       <= rx_s;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         div_reg_q    <= div_reg_d;
         act_div_q    <= act_div_d;
         half_q       <= half_d;
         fmt_bits_q   <= fmt_bits_d;
         fmt_par_q    <= fmt_par_d;
         fmt_odd_q    <= fmt_odd_d;
         fmt_stop2_q  <= fmt_stop2_d;
         sh_q         <= sh_d;
         acc_q        <= acc_d;
         sample_pulse <= sample_pulse_d;
         sample_bit   <= sample_bit_d;
         bit_idx      <= bit_idx_d;
         busy         <= busy_d;
         frame_done   <= frame_done_d;
         data_out     <= data_out_d;
         parity_err   <= parity_err_d;
         stop_err     <= stop_err_d;
         false_start  <= false_start_d;
      end
   end

   // Next-state and output logic
   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      bit_d          = bit_q;
      div_reg_d      = div_wr ? div_in : div_reg_q;
      act_div_d      = act_div_q;
      half_d         = half_q;
      fmt_bits_d     = fmt_bits_q;
      fmt_par_d      = fmt_par_q;
      fmt_odd_d      = fmt_odd_q;
      fmt_stop2_d    = fmt_stop2_q;
      sh_d           = sh_q;
      acc_d          = acc_q;
      sample_pulse_d = 1'b0;
      sample_bit_d   = sample_bit;
      bit_idx_d      = bit_idx;
      busy_d         = busy;
      frame_done_d   = 1'b0;
      data_out_d     = data_out;
      parity_err_d   = parity_err;
      stop_err_d     = stop_err;
      false_start_d  = 1'b0;

      if (state_q == IDLE) begin
         busy_d = 1'b0;
         // Start detection snapshots divisor and format for the whole frame
         if (enable && start_edge) begin
            state_d      = START;
            cnt_d        = '0;
            bit_d        = '0;
            busy_d       = 1'b1;
            act_div_d    = (div_reg_q < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : div_reg_q;
            half_d       = act_div_d >> 1;
            fmt_bits_d   = data_bits;
            fmt_par_d    = parity_en;
            fmt_odd_d    = parity_odd;
            fmt_stop2_d  = stop2;
            sh_d         = '0;
            acc_d        = 1'b0;
            parity_err_d = 1'b0;
            stop_err_d   = 1'b0;
         end
      end else begin
         cnt_d = cnt_nxt;
         if (cnt_wrap) begin
            bit_d = bit_q + 4'd1;
         end
         if (cnt_hit) begin
            if (!reject) begin
               sample_pulse_d = 1'b1;
               sample_bit_d   = rx_s;
               bit_idx_d      = bit_q;
            end
            case (state_q)
               START: begin
                  if (rx_s) begin
                     false_start_d = 1'b1;
                     state_d       = IDLE;
                     busy_d        = 1'b0;
                     cnt_d         = '0;
                     bit_d         = '0;
                  end else begin
                     state_d = DATA;
                  end
               end
               DATA: begin
                  // Shift in at the MSB; right-aligned at frame end
                  sh_d  = {rx_s, sh_q[7:1]};
                  acc_d = acc_q ^ rx_s;
                  if (bit_q == n_bits) begin
                     state_d = fmt_par_q ? PARITY : STOP;
                  end
               end
               PARITY: begin
                  parity_err_d = acc_q ^ rx_s ^ fmt_odd_q;
                  state_d      = STOP;
               end
               STOP: begin
                  stop_err_d = stop_err | ~rx_s;
                  if (bit_q == last_idx) begin
                     frame_done_d = 1'b1;
                     data_out_d   = sh_q >> (2'd3 - fmt_bits_q);
                     state_d      = IDLE;
                     busy_d       = 1'b0;
                     cnt_d        = '0;
                     bit_d        = '0;
                  end
               end
               default: begin
                  state_d = IDLE;
                  busy_d  = 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_sampler.sv
// Directed bench for uart_rx_sampler: drives serial frames bit by bit and
// checks strobe timing, decoded words and error flags against hand values.
module tb_uart_rx_sampler;

   localparam int unsigned DIV_W = 16;

   logic             ref_clk = 1'b0;
   logic             reset;
   logic             rx;
   logic             enable;
   logic             div_wr;
   logic [DIV_W-1:0] div_in;
   logic [1:0]       data_bits;
   logic             parity_en;
   logic             parity_odd;
   logic             stop2;
   logic             sample_pulse;
   logic             sample_bit;
   logic [3:0]       bit_idx;
   logic             busy;
   logic             frame_done;
   logic [7:0]       data_out;
   logic             parity_err;
   logic             stop_err;
   logic             false_start;

   uart_rx_sampler #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (15259),
      .SYNC_STAGES (2)
   ) dut (
      .ref_clk      (ref_clk),
      .reset        (reset),
      .rx           (rx),
      .enable       (enable),
      .div_wr       (div_wr),
      .div_in       (div_in),
      .data_bits    (data_bits),
      .parity_en    (parity_en),
      .parity_odd   (parity_odd),
      .stop2        (stop2),
      .sample_pulse (sample_pulse),
      .sample_bit   (sample_bit),
      .bit_idx      (bit_idx),
      .busy         (busy),
      .frame_done   (frame_done),
      .data_out     (data_out),
      .parity_err   (parity_err),
      .stop_err     (stop_err),
      .false_start  (false_start)
   );

   always #5 ref_clk = ~ref_clk;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int det_cyc  = 0;
   int n_det    = 0;
   logic busy_prev = 1'b0;
   bit found6;

   int         sp_off[$];
   logic       sp_bit[$];
   int         sp_idx[$];
   int         fd_off[$];
   logic [7:0] fd_data[$];
   logic       fd_perr[$];
   logic       fd_serr[$];
   int         fs_off[$];

   always @(posedge ref_clk) cyc <= cyc + 1;

   // Event log; offsets are in cycles from the edge that raised busy
   always @(negedge ref_clk) begin
      busy_prev <= busy;
      if (busy && !busy_prev) begin
         det_cyc <= cyc;
         n_det   <= n_det + 1;
      end
      if (sample_pulse) begin
         sp_off.push_back(cyc - det_cyc);
         sp_bit.push_back(sample_bit);
         sp_idx.push_back(int'(bit_idx));
      end
      if (frame_done) begin
         fd_off.push_back(cyc - det_cyc);
         fd_data.push_back(data_out);
         fd_perr.push_back(parity_err);
         fd_serr.push_back(stop_err);
      end
      if (false_start) fs_off.push_back(cyc - det_cyc);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic check_outputs_zero(input string tag);
      check_eq(tag, 32'({sample_pulse, sample_bit, bit_idx, busy, frame_done,
                         data_out, parity_err, stop_err, false_start}), 32'd0);
   endtask

   task automatic clear_log();
      sp_off.delete(); sp_bit.delete(); sp_idx.delete();
      fd_off.delete(); fd_data.delete(); fd_perr.delete(); fd_serr.delete();
      fs_off.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge ref_clk);
   endtask

   task automatic drive_bit(input logic b, input int n);
      rx = b;
      repeat (n) @(negedge ref_clk);
   endtask

   task automatic program_div(input int d);
      div_in = DIV_W'(d);
      div_wr = 1'b1;
      @(negedge ref_clk);
      div_wr = 1'b0;
   endtask

   task automatic set_fmt(input int nbits, input logic pe, input logic po, input logic s2);
      data_bits  = 2'(nbits - 5);
      parity_en  = pe;
      parity_odd = po;
      stop2      = s2;
   endtask

   // A bad stop holds the first stop slot low, releasing it 4 cycles early
   task automatic send_frame(input logic [7:0] data, input int nbits, input logic pe,
                             input logic pbit, input int nstop, input int div,
                             input logic bad_stop);
      logic [7:0] d;
      d = data;
      drive_bit(1'b0, div);
      for (int i = 0; i < nbits; i++) drive_bit(d[i], div);
      if (pe) drive_bit(pbit, div);
      for (int s = 0; s < nstop; s++) begin
         if (bad_stop && s == 0) begin
            drive_bit(1'b0, div - 4);
            drive_bit(1'b1, 4);
         end else begin
            drive_bit(1'b1, div);
         end
      end
   endtask

   task automatic check_samples(input string tag, input int n, input int h, input int div);
      check_eq({tag, " count"}, 32'(sp_off.size()), 32'(n));
      for (int k = 0; k < n; k++) begin
         check_eq($sformatf("%s off%0d", tag, k), 32'(sp_off[k]), 32'(h + div * k));
         check_eq($sformatf("%s idx%0d", tag, k), 32'(sp_idx[k]), 32'(k));
      end
   endtask

   initial begin
      logic [7:0] a5;
      logic       exp_b;
      int         det_before;

      reset  = 1'b0;
      rx     = 1'b1;
      enable = 1'b0;
      div_wr = 1'b0;
      div_in = '0;
      set_fmt(8, 1'b0, 1'b0, 1'b0);
      idle(3);
      check_outputs_zero("reset state");
      reset = 1'b1;
      idle(3);

      // Default divisor 15259: first sample H=7629 after detection
      enable = 1'b1;
      clear_log();
      rx = 1'b0;
      idle(7700);
      check_eq("t0 count", 32'(sp_off.size()), 32'd1);
      check_eq("t0 off", 32'(sp_off[0]), 32'd7629);
      check_eq("t0 idx", 32'(sp_idx[0]), 32'd0);
      check_eq("t0 busy", 32'(busy), 32'd1);
      reset = 1'b0;
      rx    = 1'b1;
      @(negedge ref_clk);
      check_outputs_zero("t0 reset");
      idle(3);
      reset = 1'b1;
      idle(5);

      // enable low: frame ignored entirely
      program_div(16);
      enable = 1'b0;
      clear_log();
      det_before = n_det;
      send_frame(8'h33, 8, 1'b0, 1'b0, 1, 16, 1'b0);
      idle(10);
      check_eq("ten detects", 32'(n_det - det_before), 32'd0);
      check_eq("ten samples", 32'(sp_off.size()), 32'd0);
      enable = 1'b1;

      // 8N1 0xA5 at div 16
      clear_log();
      a5 = 8'hA5;
      send_frame(a5, 8, 1'b0, 1'b0, 1, 16, 1'b0);
      idle(10);
      check_samples("t1", 10, 8, 16);
      for (int k = 0; k < 10; k++) begin
         exp_b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : a5[k-1];
         check_eq($sformatf("t1 bit%0d", k), 32'(sp_bit[k]), 32'(exp_b));
      end
      check_eq("t1 fd count", 32'(fd_off.size()), 32'd1);
      check_eq("t1 fd off", 32'(fd_off[0]), 32'd152);
      check_eq("t1 data", 32'(fd_data[0]), 32'hA5);
      check_eq("t1 perr", 32'(fd_perr[0]), 32'd0);
      check_eq("t1 serr", 32'(fd_serr[0]), 32'd0);
      check_eq("t1 busy", 32'(busy), 32'd0);

      // False start: rx low for 3 cycles only
      clear_log();
      drive_bit(1'b0, 3);
      drive_bit(1'b1, 40);
      check_eq("t2 fs count", 32'(fs_off.size()), 32'd1);
      check_eq("t2 fs off", 32'(fs_off[0]), 32'd8);
      check_eq("t2 samples", 32'(sp_off.size()), 32'd0);
      check_eq("t2 fd count", 32'(fd_off.size()), 32'd0);
      check_eq("t2 busy", 32'(busy), 32'd0);

      // 7 bits, odd parity sent as 0, two stop bits, div 20
      program_div(20);
      set_fmt(7, 1'b1, 1'b1, 1'b1);
      clear_log();
      send_frame(8'h55, 7, 1'b1, 1'b0, 2, 20, 1'b0);
      idle(10);
      check_samples("t3", 11, 10, 20);
      check_eq("t3 fd count", 32'(fd_off.size()), 32'd1);
      check_eq("t3 fd off", 32'(fd_off[0]), 32'd210);
      check_eq("t3 data", 32'(fd_data[0]), 32'h55);
      check_eq("t3 perr", 32'(fd_perr[0]), 32'd1);
      check_eq("t3 serr", 32'(fd_serr[0]), 32'd0);

      // Bad stop bit followed immediately by a good frame
      program_div(16);
      set_fmt(8, 1'b0, 1'b0, 1'b0);
      clear_log();
      send_frame(8'h3C, 8, 1'b0, 1'b0, 1, 16, 1'b1);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1, 16, 1'b0);
      idle(10);
      check_eq("t4 fd count", 32'(fd_off.size()), 32'd2);
      check_eq("t4 data0", 32'(fd_data[0]), 32'h3C);
      check_eq("t4 serr0", 32'(fd_serr[0]), 32'd1);
      check_eq("t4 data1", 32'(fd_data[1]), 32'h81);
      check_eq("t4 serr1", 32'(fd_serr[1]), 32'd0);
      check_eq("t4 perr1", 32'(fd_perr[1]), 32'd0);
      check_eq("t4 fd off1", 32'(fd_off[1]), 32'd152);

      // Divisor write mid-frame only affects the next frame
      clear_log();
      fork
         send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 16, 1'b0);
         begin
            idle(40);
            program_div(32);
         end
      join
      idle(10);
      check_samples("t5a", 10, 8, 16);
      check_eq("t5a data", 32'(fd_data[0]), 32'h5A);
      clear_log();
      send_frame(8'hC3, 8, 1'b0, 1'b0, 1, 32, 1'b0);
      idle(10);
      check_samples("t5b", 10, 16, 32);
      check_eq("t5b data", 32'(fd_data[0]), 32'hC3);

      // Reset at bit_idx 4, then a clean frame after release
      program_div(16);
      clear_log();
      found6 = 1'b0;
      fork
         send_frame(8'h96, 8, 1'b0, 1'b0, 1, 16, 1'b0);
         begin
            for (int i = 0; i < 200 && !found6; i++) begin
               @(negedge ref_clk);
               if (sample_pulse && bit_idx == 4'd4) begin
                  found6 = 1'b1;
                  reset  = 1'b0;
               end
            end
            if (found6) begin
               @(negedge ref_clk);
               check_outputs_zero("t6 reset");
            end else begin
               check_eq("t6 reach idx4", 32'd0, 32'd1);
            end
         end
      join
      idle(3);
      check_eq("t6 no fd", 32'(fd_off.size()), 32'd0);
      reset = 1'b1;
      idle(5);
      program_div(16);
      clear_log();
      send_frame(8'h96, 8, 1'b0, 1'b0, 1, 16, 1'b0);
      idle(10);
      check_eq("t6 fd count", 32'(fd_off.size()), 32'd1);
      check_eq("t6 data", 32'(fd_data[0]), 32'h96);

      // Divisor below minimum clamps to 4
      program_div(2);
      clear_log();
      send_frame(8'h0F, 8, 1'b0, 1'b0, 1, 4, 1'b0);
      idle(10);
      check_samples("t7", 10, 2, 4);
      check_eq("t7 fd off", 32'(fd_off[0]), 32'd38);
      check_eq("t7 data", 32'(fd_data[0]), 32'h0F);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- Parametrised successor to the fixed 500 MHz / 32768 bps baud generator.
- Detects a UART start bit on the raw Rx line and emits one-cycle mid-bit sample strobes from a runtime-programmable divisor.
- Supports runtime frame format: 5–8 data bits, optional odd/even parity, 1 or 2 stop bits.
- Assembles the data word, checks parity and stop bits, and rejects false starts. Sits between the Rx pin and the packet deframer.

Parameters:
- DIV_W, 16, width of divisor and clock counter.
- DEFAULT_DIV, 15259, divisor loaded at reset (500 MHz / 32768 bps).
- SYNC_STAGES, 2, flip-flop stages on the rx synchroniser (minimum 2).

Ports:
- ref_clk  in  1  reference clock; all logic on posedge.
- reset  in  1  synchronous active-low reset.
- rx  in  1  asynchronous serial line; idles high.
- enable  in  1  permits detection of new start bits.
- div_wr  in  1  one-cycle strobe; loads div_in into the divisor register.
- div_in  in  DIV_W  ref_clk cycles per baud.
- data_bits  in  2  0/1/2/3 → 5/6/7/8 data bits.
- parity_en  in  1  frame contains a parity bit.
- parity_odd  in  1  1 = odd parity, 0 = even parity.
- stop2  in  1  1 = two stop bits, 0 = one stop bit.
- sample_pulse  out  1  one-cycle strobe at each bit centre.
- sample_bit  out  1  synchronised rx value at sample_pulse.
- bit_idx  out  4  frame bit index of the current sample (0 = start bit).
- busy  out  1  high from start detection until return to IDLE.
- frame_done  out  1  one-cycle pulse; data_out valid in the same cycle.
- data_out  out  8  received word, LSB-first, right-aligned, upper bits 0.
- parity_err  out  1  valid with frame_done.
- stop_err  out  1  valid with frame_done.
- false_start  out  1  one-cycle pulse on a rejected start bit.

Behaviour:
- Reset (reset==0 at posedge):
  - state=IDLE; counters 0; divisor=DEFAULT_DIV.
  - Synchroniser and edge-history flops set to 1.
  - All outputs 0.
- Divisor:
  - Divisor register written on div_wr in any state.
  - Active divisor is copied from the register at start detection; a write mid-frame affects only the next frame.
  - Effective divisor = max(div, 4).
  - Half-point H = div>>1 (truncating).
- Frame format (data_bits, parity_en, parity_odd, stop2):
  - Latched at start detection with the divisor.
  - N = data_bits+5; P = parity_en; S = stop2+1.
  - Total bits T = 1+N+P+S; bit_idx runs 0..T-1.
- Start detection:
  - In IDLE with enable=1, falling edge on synchronised rx (prev=1, cur=0).
  - That cycle: clk_cnt←0, busy←1, state←START.
  - Edges while enable=0 are ignored.
- Counter:
  - clk_cnt increments every cycle while busy and wraps at div-1 to 0.
  - Each wrap increments bit_idx.
  - Sample point: clk_cnt==H, i.e. H cycles after detection, then every div cycles.
- START state:
  - At sample point, if rx=1: pulse false_start, go to IDLE; no sample_pulse.
  - Else: sample_pulse, bit_idx=0, go to DATA.
- DATA state:
  - Each sample shifts rx into data_out MSB-first and XORs it into the parity accumulator.
  - After sample N, go to PARITY if P else STOP.
  - Final word = data_out >> (8-N).
- PARITY state:
  - parity_err ← (acc ^ sample ^ parity_odd) != 0, i.e. mismatch against the selected odd/even sense.
- STOP state:
  - Any stop sample = 0 sets the sticky stop_err for the frame.
  - At the last stop sample: pulse frame_done with data_out, parity_err, stop_err; state←IDLE; busy←0 the next cycle.
  - A start edge is accepted from the cycle after frame_done, allowing back-to-back frames with no idle gap.
- Status flags:
  - parity_err and stop_err hold until the next start detection.
  - parity_err=0 when P=0.
- enable deasserted mid-frame: the current frame completes normally.
- Reset mid-frame: IDLE on the next edge, no frame_done, all outputs 0.
- Latency: rx fall to detection = SYNC_STAGES+1 cycles.

Test Plan:
- div=16, 8N1, send 0xA5: sample_pulses at detection+8+16k for k=0..9; frame_done at k=9 with data_out=0xA5, parity_err=0, stop_err=0.
- div=16, rx low for 3 cycles then high: exactly one false_start pulse 8 cycles after detection, no sample_pulse, back in IDLE, busy=0.
- div=20, 7 bits, parity_en=1, parity_odd=1, stop2=1, send 0x55 with parity bit 0: data_out=0x55, parity_err=1 (odd sense requires parity bit 1), T=11 samples.
- div=16, 8N1, stop bit driven 0 then next start immediately: frame_done with stop_err=1; next frame still received correctly.
- div_wr to div=32 during a div=16 frame: current frame keeps 16-cycle spacing; next frame samples at 16+32k.
- reset=0 at bit_idx 4: all outputs 0 next cycle, no frame_done; frame sent after release decodes correctly. Also div_in=2 → samples every 4 cycles.
